// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check used at acceptance time.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    ERR
  } lsu_state_t;

  // Misalignment and illegal width codes; the address range check lives in the
  // top because it depends on ADDR_WIDTH.
  function automatic logic lsu_bad_access(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] byte_off);
    logic bad;
    bad = 1'b0;
    case (funct3)
      LB:      bad = 1'b0;
      LH:      bad = byte_off[0];
      LW:      bad = |byte_off;
      LBU:     bad = we;
      LHU:     bad = we | byte_off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: extracts and extends load data,
// and merges a sub-word store into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    shamt     = {byte_off, 3'b000};
    shifted   = rdata >> shamt;
    load_data = shifted;
    case (funct3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_data = {24'd0, shifted[7:0]};
      LHU:     load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase

    // Only SB and SH reach the merge path, so bit 0 picks byte vs half.
    lane_mask = (funct3 == SH) ? 32'h0000_FFFF : 32'h0000_00FF;
    lane_mask = lane_mask << shamt;
    merged    = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a single-port word
// memory, with read-modify-write for byte and halfword stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic                  req_fire;
  logic                  req_err;
  logic                  mem_we_int;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  assign req_ready = (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;
  assign req_err   = lsu_bad_access(req_we, req_funct3, req_addr[1:0])
                   || (|(req_addr >> (ADDR_WIDTH + 2)));
  assign mem_we    = mem_we_int && !rst;

  lsu_align u_align (
    .funct3    (funct3_q),
    .byte_off  (addr_q[1:0]),
    .rdata     (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d    = state_q;
    mem_we_int = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q != IDLE) mem_addr = addr_q[ADDR_WIDTH+1:2];
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_err)                state_d = ERR;
          else if (!req_we)           state_d = LOAD;
          else if (req_funct3 == SW)  state_d = WRITE;
          else                        state_d = RMW_READ;
        end
      end
      LOAD:      state_d = IDLE;
      WRITE: begin
        mem_we_int = 1'b1;
        mem_wdata  = wdata_q;
        state_d    = IDLE;
      end
      RMW_READ:  state_d = RMW_WRITE;
      RMW_WRITE: begin
        mem_we_int = 1'b1;
        mem_wdata  = merged_q;
        state_d    = IDLE;
      end
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Responses are registered out of the final state so they land in IDLE,
  // where the next request can already be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      if (req_fire) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_WIDTH+1:0];
        wdata_q  <= req_wdata;
      end
      case (state_q)
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? '0 : load_data;
          resp_err   <= 1'b0;
        end
        WRITE, RMW_WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        RMW_READ: merged_q <= merged;
        ERR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random traffic checked
// against a byte-addressed little-endian memory model.
module tb_load_store_unit;

  localparam int AW     = 10;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0]   dmem [0:(1<<AW)-1];
  logic [7:0]    ref_bytes [0:NBYTES-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_data = '0;
  int            we_pulses = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [31:0]   prev_rdata = '0;
  logic          prev_err = 1'b0;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr];

  // Word RAM attached to the DUT; the poke port preloads it between requests.
  always @(posedge clk) begin
    if (poke_en) dmem[poke_addr] <= poke_data;
    else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
      we_pulses      <= we_pulses + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic pokeWord(input int w, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_addr = AW'(w);
    poke_data = d;
    for (int i = 0; i < 4; i++) ref_bytes[4*w+i] = d[8*i +: 8];
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Architectural behaviour of one request on the byte memory model.
  function automatic void refModel(input logic we, input int f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic err, output logic [31:0] rdata,
                                   output int lat, output int writes);
    int size;
    size   = 1 << (f3 % 4);
    err    = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4) || (addr >= 32'(NBYTES))
          || ((f3 % 4 == 1) && (addr % 2 != 0)) || ((f3 == 2) && (addr % 4 != 0));
    rdata  = 32'd0;
    lat    = 2;
    writes = 0;
    if (err) return;
    if (!we) begin
      for (int i = 0; i < size; i++) rdata |= 32'(ref_bytes[int'(addr) + i]) << (8*i);
      if (f3 < 4 && size < 4 && rdata[8*size-1]) rdata |= 32'hFFFF_FFFF << (8*size);
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
      writes = 1;
      lat    = (size == 4) ? 2 : 3;
    end
  endfunction

  // Called just after a falling edge with the DUT idle; returns at the falling
  // edge where resp_valid is seen, so a following call is back-to-back.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_writes, lat, pulses0;
    refModel(we, int'(f3), addr, wdata, exp_err, exp_rdata, exp_lat, exp_writes);
    pulses0 = we_pulses;
    checkOutput({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      checkOutput({tag, "/hold_rdata"}, resp_rdata, prev_rdata);
      checkOutput({tag, "/hold_err"}, 32'(resp_err), 32'(prev_err));
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom_range(0, NBYTES - 1);
      req_wdata  = $urandom;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    checkOutput({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "/rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "/err"}, 32'(resp_err), 32'(exp_err));
    checkOutput({tag, "/mem_we_pulses"}, 32'(we_pulses - pulses0), 32'(exp_writes));
    if (addr < 32'(NBYTES))
      checkOutput({tag, "/word"}, dmem[int'(addr[AW+1:2])], refWord(int'(addr[AW+1:2])));
    prev_rdata = exp_rdata;
    prev_err   = exp_err;
  endtask

  initial begin
    int          pulses0;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst/resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst/resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst/resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst/mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst/ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < (1 << AW); w++) pokeWord(w, $urandom);

    pokeWord(4, 32'h8899_AABB);
    applyStimulus("lb_0x12", 1'b0, 3'd0, 32'h12, 32'h0);
    checkOutput("lb_0x12/const", resp_rdata, 32'hFFFF_FF99);
    applyStimulus("lbu_0x12", 1'b0, 3'd4, 32'h12, 32'h0);
    checkOutput("lbu_0x12/const", resp_rdata, 32'h0000_0099);

    pokeWord(4, 32'h1122_3344);
    applyStimulus("sb_0x11", 1'b1, 3'd0, 32'h11, 32'h0000_00A5);
    checkOutput("sb_0x11/const", dmem[4], 32'h1122_A544);

    applyStimulus("sh_0x13", 1'b1, 3'd1, 32'h13, 32'h0000_BEEF);
    checkOutput("sh_0x13/err_const", 32'(resp_err), 32'd1);
    applyStimulus("lw_0x1000", 1'b0, 3'd2, 32'h1000, 32'h0);
    checkOutput("lw_0x1000/err_const", 32'(resp_err), 32'd1);

    applyStimulus("sw_0x20", 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
    checkOutput("b2b/resp_valid", 32'(resp_valid), 32'd1);
    applyStimulus("lw_0x20", 1'b0, 3'd2, 32'h20, 32'h0);
    checkOutput("lw_0x20/const", resp_rdata, 32'hDEAD_BEEF);

    // Reset lands while the halfword store is in its write-back cycle.
    pokeWord(9, 32'h5566_7788);
    pulses0    = we_pulses;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd1;
    req_addr   = 32'h26;
    req_wdata  = 32'h0000_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rmw_rst/mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rmw_rst/ready", 32'(req_ready), 32'd1);
    checkOutput("rmw_rst/resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rmw_rst/resp_rdata", resp_rdata, 32'd0);
    checkOutput("rmw_rst/pulses", 32'(we_pulses - pulses0), 32'd0);
    checkOutput("rmw_rst/word", dmem[9], 32'h5566_7788);
    prev_rdata = '0;
    prev_err   = 1'b0;
    @(negedge clk);
    checkOutput("rmw_rst/resp_valid2", 32'(resp_valid), 32'd0);

    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else begin
        addr = $urandom_range(0, NBYTES - 1);
        if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      end
      applyStimulus("rand", we, f3, addr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the word-address width of the attached data memory (2^ADDR_WIDTH words).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the core presents a memory request.
REQ-006 SHALL have port req_ready  output  1  the block accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-009 SHALL have port req_addr  input  32  the byte address.
REQ-010 SHALL have port req_wdata  input  32  the store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  the extended load data, valid with resp_valid.
REQ-013 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal request, valid with resp_valid.
REQ-014 SHALL have port mem_we  output  1  the data-memory write enable.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  the data-memory word address.
REQ-016 SHALL have port mem_wdata  output  32  the data-memory write word.
REQ-017 SHALL have port mem_rdata  input  32  the data-memory read word, combinational from mem_addr.

Function
REQ-018 SHALL accept a request on a rising edge with req_valid && req_ready, registering we, funct3, addr and wdata.
REQ-019 SHALL drive req_ready=1 only in state IDLE.
REQ-020 SHALL implement the FSM states IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE and ERR.
REQ-021 SHALL transition from IDLE on acceptance to ERR (error), LOAD (load), WRITE (SW) or RMW_READ (SB/SH).
REQ-022 SHALL transition LOAD, WRITE, RMW_WRITE and ERR to IDLE, and RMW_READ to RMW_WRITE, after one cycle.
REQ-023 SHALL drive mem_addr = registered addr[ADDR_WIDTH+1:2] in all non-IDLE states, and 0 in IDLE.
REQ-024 SHALL latch mem_rdata in LOAD, select the byte/half by addr[1:0], sign-extend for B/H and zero-extend for BU/HU.
REQ-025 SHALL assert mem_we with mem_wdata = req_wdata in WRITE.
REQ-026 SHALL latch mem_rdata in RMW_READ with the addressed byte/half replaced by req_wdata[7:0]/[15:0] and other bytes preserved.
REQ-027 SHALL assert mem_we in RMW_WRITE with the merged word.
REQ-028 SHALL leave mem_we at 0 in every other state.
REQ-029 SHALL register resp_valid, pulsing it for one cycle after the final state: latency acceptance->resp_valid is 2 cycles for loads, SW and errors, and 3 for SB/SH.
REQ-030 SHALL hold resp_rdata and resp_err stable until the next resp_valid, with resp_rdata=0 for stores and errors.
REQ-031 SHALL raise resp_err for: H/HU/SH with addr[0]=1; W with addr[1:0]!=0; funct3 3, 6 or 7; store funct3 4 or 5; addr[31:ADDR_WIDTH+2] nonzero.
REQ-032 SHALL make no memory access and no mem_we on error.
REQ-033 SHALL allow resp_valid of request N to coincide with acceptance of request N+1 in IDLE.
REQ-034 SHALL ignore req_* while req_ready=0, with no queueing.
REQ-035 SHALL perform byte-address wrap only within the range check, with no modular aliasing.

Reset
REQ-036 SHALL, while rst=1 at a rising edge, force state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0 and all captured registers to 0.
REQ-037 SHALL gate mem_we with !rst so that no write occurs during any cycle rst is high, including reset mid-RMW.
REQ-038 SHALL, after reset, return req_ready=1 in the first cycle with rst low.

Structure
REQ-039 SHALL place funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state enum in shared package lsu_pkg.
REQ-040 SHALL implement load extraction and store merge (byte-lane select, extend, merge) in the combinational sub-module lsu_align.

Verification
REQ-041 SHALL cover: mem[4]=0x8899AABB, LB at 0x12 -> resp_rdata=0xFFFFFF99, LBU at 0x12 -> 0x00000099, 2 cycles after acceptance.
REQ-042 SHALL cover: mem[4]=0x11223344, SB 0xA5 at 0x11 -> mem[4]=0x1122A544, mem_we high exactly one cycle, resp_valid 3 cycles after acceptance.
REQ-043 SHALL cover: SH 0xBEEF at 0x13 -> resp_err=1, no mem_we; LW at 0x1000 with ADDR_WIDTH=10 -> resp_err=1.
REQ-044 SHALL cover: back-to-back SW 0xDEADBEEF at 0x20 then LW at 0x20 -> second response 0xDEADBEEF, second request accepted in the cycle of the first resp_valid.
REQ-045 SHALL cover: rst asserted during RMW_WRITE of SH -> no mem_we, target word unchanged, resp_valid=0, req_ready=1 after release.
